sfx_scheduler: RTL and testbench

SFX_SCHEDULER -- requirements
Module: sfx_scheduler

---
 rtl/apu_pkg.sv | 29 ++
 rtl/sfx_scheduler_rr_arb4.sv | 37 +++
 rtl/sfx_scheduler.sv | 174 +++++++++++++++++
 tb/tb_sfx_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// -----------------------------------------------------------------------------
// apu_pkg
//   Shared APU definitions used by the sound-effect scheduler and its
//   round-robin arbiter.
//
//   Contents:
//     sfx_state_e  - scheduler FSM state encoding
//     req_id_t     - 2-bit requester index (four requesters)
//     RESET_LAST   - last-winner value after reset, so requester 0 wins first
//     id_onehot()  - requester index to one-hot grant vector
// -----------------------------------------------------------------------------
package apu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_PLAY    = 2'd2,
        ST_RELEASE = 2'd3
    } sfx_state_e;

    typedef logic [1:0] req_id_t;

    localparam req_id_t RESET_LAST = 2'd3;

    function automatic logic [3:0] id_onehot(input req_id_t id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/sfx_scheduler_rr_arb4.sv
// -----------------------------------------------------------------------------
// rr_arb4
//   Four-way round-robin arbiter, purely combinational.  The search starts at
//   last+1 (mod 4) and wraps, so the most recent winner has lowest priority.
//
//   Ports:
//     req    [3:0] in   request vector
//     last   [1:0] in   index of previous winner
//     winner [1:0] out  selected requester (0 when no request)
//     valid        out  at least one request present
// -----------------------------------------------------------------------------
module rr_arb4
    import apu_pkg::*;
(
    input  logic [3:0] req,
    input  req_id_t    last,
    output req_id_t    winner,
    output logic       valid
);

    req_id_t idx;

    // Walk candidates from farthest to nearest so the closest requester
    // after 'last' is the one left standing.
    always_comb begin
        idx    = '0;
        winner = '0;
        valid  = |req;
        for (int i = 3; i >= 0; i--) begin
            idx = last + 2'(i) + 2'd1;
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/sfx_scheduler.sv
// -----------------------------------------------------------------------------
// sfx_scheduler
//   Arbitrates four sound-effect requesters and plays the winner's tone
//   override word for a number of note ticks.  The override nibbles drive the
//   APU oneshot override inputs directly; a zero nibble lets music through.
//
//   Ports:
//     clk, reset            system clock, async active-high reset
//     note_clk              beat level from the beat counter (async to clk)
//     req      [3:0]        per-requester level request, held until grant
//     sfx0..3  [15:0]       tone words {t0,t1,t2,t3}
//     dur0..3  [DUR_W-1:0]  play length in note ticks (0 plays as 1)
//     abort                 terminate the playing effect
//     grant    [3:0]        one-hot, one-cycle accept pulse
//     t0_os..t3_os [3:0]    tone overrides, zero when not playing
//     busy                  effect playing
//     active_id [1:0]       requester being served, valid while busy
//     done                  one-cycle pulse when playback ends
// -----------------------------------------------------------------------------
module sfx_scheduler
    import apu_pkg::*;
#(
    parameter int DUR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             note_clk,
    input  logic [3:0]       req,
    input  logic [15:0]      sfx0,
    input  logic [15:0]      sfx1,
    input  logic [15:0]      sfx2,
    input  logic [15:0]      sfx3,
    input  logic [DUR_W-1:0] dur0,
    input  logic [DUR_W-1:0] dur1,
    input  logic [DUR_W-1:0] dur2,
    input  logic [DUR_W-1:0] dur3,
    input  logic             abort,
    output logic [3:0]       grant,
    output logic [3:0]       t0_os,
    output logic [3:0]       t1_os,
    output logic [3:0]       t2_os,
    output logic [3:0]       t3_os,
    output logic             busy,
    output logic [1:0]       active_id,
    output logic             done
);

    // -------------------------------------------------------------------------
    // note_clk synchronizer: [0],[1] are the two sync stages, [2] holds the
    // previous synchronized level for rising-edge detection.
    // -------------------------------------------------------------------------
    logic [2:0] sync_q, sync_d;
    logic       tick;

    assign sync_d = {sync_q[1:0], note_clk};
    assign tick   = sync_q[1] & ~sync_q[2];

    // -------------------------------------------------------------------------
    // Requester input selection
    // -------------------------------------------------------------------------
    logic [3:0][15:0]      sfx_in;
    logic [3:0][DUR_W-1:0] dur_in;

    assign sfx_in = {sfx3, sfx2, sfx1, sfx0};
    assign dur_in = {dur3, dur2, dur1, dur0};

    // -------------------------------------------------------------------------
    // Arbiter
    // -------------------------------------------------------------------------
    req_id_t last_q, last_d;
    req_id_t arb_winner;
    logic    arb_valid;

    rr_arb4 u_arb (
        .req    (req),
        .last   (last_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // -------------------------------------------------------------------------
    // FSM and playback state
    // -------------------------------------------------------------------------
    sfx_state_e       state_q, state_d;
    req_id_t          active_q, active_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [15:0]      sfx_q, sfx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            state_q  <= ST_IDLE;
            active_q <= '0;
            last_q   <= RESET_LAST;
            cnt_q    <= '0;
            sfx_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            active_q <= active_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            sfx_q    <= sfx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        sfx_d    = sfx_q;

        unique case (state_q)
            ST_IDLE: begin
                // Winner is fixed here; a requester that dropped req before
                // this cycle simply never shows up in the arbitration.
                if (arb_valid) begin
                    active_d = arb_winner;
                    state_d  = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // Snapshot the word and length; later input changes are
                // invisible to the running effect.  A tick landing in this
                // cycle is not counted.
                sfx_d   = sfx_in[active_q];
                cnt_d   = (dur_in[active_q] == '0) ? DUR_W'(1) : dur_in[active_q];
                last_d  = active_q;
                state_d = ST_PLAY;
            end

            ST_PLAY: begin
                // Abort and the final tick both lead to the same single
                // RELEASE cycle, so coincidence still yields one done pulse.
                if (abort) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (tick) begin
                    if (cnt_q == DUR_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs are decoded from registered state so an async reset clears the
    // overrides in the same cycle without a done pulse.
    // -------------------------------------------------------------------------
    assign grant     = (state_q == ST_GRANT) ? id_onehot(active_q) : 4'b0000;
    assign busy      = (state_q == ST_PLAY);
    assign done      = (state_q == ST_RELEASE);
    assign active_id = active_q;

    assign t0_os = busy ? sfx_q[15:12] : 4'h0;
    assign t1_os = busy ? sfx_q[11:8]  : 4'h0;
    assign t2_os = busy ? sfx_q[7:4]   : 4'h0;
    assign t3_os = busy ? sfx_q[3:0]   : 4'h0;

endmodule

// File: tb/tb_sfx_scheduler.sv
module tb_sfx_scheduler;

    localparam int DUR_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             note_clk = 1'b0;
    logic             abort = 1'b0;
    logic [3:0]       req = '0;
    logic [15:0]      sfx0 = '0, sfx1 = '0, sfx2 = '0, sfx3 = '0;
    logic [DUR_W-1:0] dur0 = '0, dur1 = '0, dur2 = '0, dur3 = '0;
    logic [3:0]       grant;
    logic [3:0]       t0_os, t1_os, t2_os, t3_os;
    logic             busy, done;
    logic [1:0]       active_id;

    sfx_scheduler #(.DUR_W(DUR_W)) dut (
        .clk(clk), .reset(reset), .note_clk(note_clk), .req(req),
        .sfx0(sfx0), .sfx1(sfx1), .sfx2(sfx2), .sfx3(sfx3),
        .dur0(dur0), .dur1(dur1), .dur2(dur2), .dur3(dur3),
        .abort(abort), .grant(grant),
        .t0_os(t0_os), .t1_os(t1_os), .t2_os(t2_os), .t3_os(t3_os),
        .busy(busy), .active_id(active_id), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    logic [15:0] os_w;
    assign os_w = {t0_os, t1_os, t2_os, t3_os};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: phase 0 idle, 1 grant, 2 play, 3 release.
    // Ticks are beat rising edges seen two clocks late (sync delay).
    // ---------------------------------------------------------------------
    int          m_ph = 0, m_cur = 0, m_last = 3, m_rem = 0;
    logic [15:0] m_word = '0;
    logic        s1 = 0, s2 = 0, s3 = 0, tk;
    logic        found;
    logic [3:0]  exp_g;
    logic [15:0] exp_os;

    function automatic logic [15:0] sfx_of(input int i);
        case (i)
            0: return sfx0;
            1: return sfx1;
            2: return sfx2;
            default: return sfx3;
        endcase
    endfunction

    function automatic int dur_of(input int i);
        case (i)
            0: return int'(dur0);
            1: return int'(dur1);
            2: return int'(dur2);
            default: return int'(dur3);
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph = 0; m_cur = 0; m_last = 3; m_rem = 0; m_word = '0;
            s1 = 0; s2 = 0; s3 = 0;
        end else begin
            tk = s2 & ~s3;
            s3 = s2; s2 = s1; s1 = note_clk;
            case (m_ph)
                0: if (req != 0) begin
                    found = 0;
                    for (int k = 1; k <= 4; k++) begin
                        if (!found && req[(m_last + k) % 4]) begin
                            m_cur = (m_last + k) % 4;
                            found = 1;
                        end
                    end
                    m_ph = 1;
                end
                1: begin
                    m_word = sfx_of(m_cur);
                    m_rem  = dur_of(m_cur);
                    if (m_rem == 0) m_rem = 1;
                    m_last = m_cur;
                    m_ph   = 2;
                end
                2: if (abort) m_ph = 3;
                   else if (tk) begin
                       m_rem--;
                       if (m_rem == 0) m_ph = 3;
                   end
                default: m_ph = 0;
            endcase
        end
    end

    // Per-cycle compare against the model, away from the clock edge.
    always @(posedge clk) begin
        #3;
        if (!reset) begin
            exp_g  = (m_ph == 1) ? (4'b0001 << m_cur) : 4'b0000;
            exp_os = (m_ph == 2) ? m_word : 16'h0000;
            chk("cycle", {grant, os_w, busy, done},
                {exp_g, exp_os, (m_ph == 2), (m_ph == 3)});
            if (m_ph == 2) chk("active_id", 32'(active_id), 32'(m_cur));
            if (done) done_cnt++;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic do_reset;
        req = '0; abort = 0; note_clk = 0;
        reset = 1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {grant, os_w, busy, done, active_id}, 32'h0);
        reset = 0;
    endtask

    task automatic note(input int gap);
        repeat (gap) @(negedge clk);
        note_clk = 1;
        repeat (3) @(negedge clk);
        note_clk = 0;
    endtask

    task automatic wait_grant(output int id);
        int i;
        i = 0; id = -1;
        while (grant == 0 && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (grant == 0) chk("grant_timeout", 0, 1);
        else for (int b = 0; b < 4; b++) if (grant[b]) id = b;
    endtask

    task automatic wait_done;
        int i;
        i = 0;
        while (!done && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    int id, d0, g;
    int ids[5];

    initial begin
        @(negedge clk);

        // Basic play: 1230 for 3 ticks spaced 100 clocks
        do_reset();
        sfx0 = 16'h1230; dur0 = 8'd3; req = 4'b0001;
        wait_grant(id);
        chk("t1_grant", 32'(grant), 32'h1);
        req = 0;
        d0 = done_cnt;
        @(negedge clk);
        chk("t1_overrides", 32'(os_w), 32'h1230);
        chk("t1_busy", 32'(busy), 32'h1);
        note(100); note(100);
        repeat (10) @(negedge clk);
        chk("t1_busy_after_2_ticks", 32'(busy), 32'h1);
        note(100);
        wait_done();
        repeat (5) @(negedge clk);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // Round robin with all four requesting
        do_reset();
        sfx0 = 16'h1111; sfx1 = 16'h2222; sfx2 = 16'h3333; sfx3 = 16'h4444;
        dur0 = 1; dur1 = 1; dur2 = 1; dur3 = 1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(id);
            ids[k] = id;
            note(2);
            wait_done();
            if (k == 4) req = 0;
        end
        chk("rr_0", ids[0], 0);
        chk("rr_1", ids[1], 1);
        chk("rr_2", ids[2], 2);
        chk("rr_3", ids[3], 3);
        chk("rr_4", ids[4], 0);

        // Zero duration plays one tick
        do_reset();
        sfx1 = 16'h0A0B; dur1 = 0; req = 4'b0010;
        wait_grant(id);
        chk("dur0_id", id, 1);
        req = 0;
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        chk("dur0_busy_no_tick", 32'(busy), 32'h1);
        note(2);
        wait_done();
        repeat (3) @(negedge clk);
        chk("dur0_done_once", done_cnt - d0, 1);

        // Abort mid-play, then next request served
        do_reset();
        sfx0 = 16'h4567; dur0 = 8; req = 4'b0001;
        wait_grant(id);
        req = 0;
        repeat (5) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_os_clear", 32'(os_w), 32'h0);
        chk("abort_done", 32'(done), 32'h1);
        sfx2 = 16'h9876; dur2 = 1; req = 4'b0100;
        wait_grant(id);
        chk("after_abort_id", id, 2);

        // Reset mid-play: outputs clear at once, no done
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        reset = 1;
        #1;
        chk("rst_mid_outputs", {grant, os_w, busy, done, active_id}, 32'h0);
        @(negedge clk);
        reset = 0;
        wait_grant(id);
        chk("rst_then_id", id, 2);
        req = 0;
        note(2);
        wait_done();
        chk("rst_no_extra_done", done_cnt - d0, 1);

        // Inputs changed during play do not leak; dropped request is lost
        do_reset();
        sfx0 = 16'h1230; dur0 = 2; req = 4'b0001;
        wait_grant(id);
        req = 0;
        @(negedge clk);
        sfx0 = 16'hFFFF; dur0 = 50; req = 4'b0010;
        repeat (3) @(negedge clk);
        req = 0;
        chk("latched_os_a", 32'(os_w), 32'h1230);
        note(2);
        chk("latched_os_b", 32'(os_w), 32'h1230);
        note(2);
        wait_done();
        g = 0;
        repeat (10) begin
            @(negedge clk);
            if (grant != 0) g++;
        end
        chk("dropped_req_no_grant", g, 0);

        // Tick expiry and abort in the same cycle: one done
        do_reset();
        sfx0 = 16'h5555; dur0 = 1; req = 4'b0001;
        wait_grant(id);
        req = 0;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        note_clk = 1;
        @(negedge clk);
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0; note_clk = 0;
        chk("coincide_done", 32'(done), 32'h1);
        repeat (5) @(negedge clk);
        chk("coincide_single_done", done_cnt - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
